// File: rtl/alu_serial.sv
// Digit-serial ALU: one 4-bit digit per clock with a chained carry, start/busy/done handshake.
// Define ALU_SERIAL_DECIMAL_EN to build the DAA and KBP lookups; otherwise ops 5/6 act as PASS.
module alu_serial #(
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout,
  output logic                  zero
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_ROL = 3'd2;
  localparam logic [2:0] OP_ROR = 3'd3;
`ifdef ALU_SERIAL_DECIMAL_EN
  localparam logic [2:0] OP_DAA = 3'd5;
  localparam logic [2:0] OP_KBP = 3'd6;

  // One-hot-to-index lookup; bit 4 flags a non-power-of-two input.
  function automatic logic [4:0] kbp_lookup(input logic [3:0] d);
    case (d)
      4'h0:    kbp_lookup = 5'b0_0000;
      4'h1:    kbp_lookup = 5'b0_0001;
      4'h2:    kbp_lookup = 5'b0_0010;
      4'h4:    kbp_lookup = 5'b0_0011;
      4'h8:    kbp_lookup = 5'b0_0100;
      default: kbp_lookup = 5'b1_1111;
    endcase
  endfunction
`endif

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, work_q, work_d;
  logic [2:0]      op_q, op_d;
  logic            c_q, c_d;
  logic            done_q, done_d, cout_q, cout_d, zero_q, zero_d;
  logic [W-1:0]    result_q, result_d;
`ifdef ALU_SERIAL_DECIMAL_EN
  logic            inv_q, inv_d, inv_nxt_s;
  logic [4:0]      kbp_s, adj_s;
`endif

  logic [CW-1:0]   idx_s;
  logic [CW+1:0]   base_s;
  logic [3:0]      d_s, e_s, digit_s;
  logic [4:0]      sum_s;
  logic            c_nxt_s, cout_fin_s;
  logic [W-1:0]    work_s;

  // Per-digit datapath: select the active digit and compute its result and outgoing carry.
  always_comb begin
    idx_s   = (op_q == OP_ROR) ? (LAST - cnt_q) : cnt_q;
    base_s  = {idx_s, 2'b00};
    d_s     = a_q[base_s +: 4];
    e_s     = b_q[base_s +: 4];
    sum_s   = 5'd0;
    digit_s = d_s;
    c_nxt_s = c_q;
`ifdef ALU_SERIAL_DECIMAL_EN
    kbp_s     = 5'd0;
    adj_s     = 5'd0;
    inv_nxt_s = inv_q;
`endif
    case (op_q)
      OP_ADD: begin
        sum_s   = {1'b0, d_s} + {1'b0, e_s} + {4'b0000, c_q};
        digit_s = sum_s[3:0];
        c_nxt_s = sum_s[4];
      end
      OP_SUB: begin
        sum_s   = {1'b0, d_s} + {1'b0, ~e_s} + {4'b0000, c_q};
        digit_s = sum_s[3:0];
        c_nxt_s = sum_s[4];
      end
      OP_ROL: begin
        digit_s = {d_s[2:0], c_q};
        c_nxt_s = d_s[3];
      end
      OP_ROR: begin
        digit_s = {c_q, d_s[3:1]};
        c_nxt_s = d_s[0];
      end
`ifdef ALU_SERIAL_DECIMAL_EN
      OP_DAA: begin
        sum_s = {1'b0, d_s} + {4'b0000, c_q};
        adj_s = sum_s + 5'd6;
        if (sum_s > 5'd9) begin
          digit_s = adj_s[3:0];
          c_nxt_s = 1'b1;
        end else begin
          digit_s = sum_s[3:0];
          c_nxt_s = 1'b0;
        end
      end
      OP_KBP: begin
        kbp_s     = kbp_lookup(d_s);
        digit_s   = kbp_s[3:0];
        inv_nxt_s = inv_q | kbp_s[4];
      end
`endif
      default: begin
        digit_s = d_s;
        c_nxt_s = c_q;
      end
    endcase
    work_s = work_q;
    work_s[base_s +: 4] = digit_s;
`ifdef ALU_SERIAL_DECIMAL_EN
    cout_fin_s = (op_q == OP_KBP) ? inv_nxt_s : c_nxt_s;
`else
    cout_fin_s = c_nxt_s;
`endif
  end

  // FSM next state, operand capture on accept, and completion update of the visible outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    c_d      = c_q;
    work_d   = work_q;
    done_d   = 1'b0;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
`ifdef ALU_SERIAL_DECIMAL_EN
    inv_d    = inv_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          op_d    = op;
          c_d     = cin;
          cnt_d   = {CW{1'b0}};
          work_d  = {W{1'b0}};
`ifdef ALU_SERIAL_DECIMAL_EN
          inv_d   = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        work_d = work_s;
        c_d    = c_nxt_s;
`ifdef ALU_SERIAL_DECIMAL_EN
        inv_d  = inv_nxt_s;
`endif
        if (cnt_q == LAST) begin
          state_d  = IDLE;
          result_d = work_s;
          cout_d   = cout_fin_s;
          zero_d   = (work_s == {W{1'b0}});
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1'b1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= {CW{1'b0}};
      a_q      <= {W{1'b0}};
      b_q      <= {W{1'b0}};
      op_q     <= 3'd0;
      c_q      <= 1'b0;
      work_q   <= {W{1'b0}};
      done_q   <= 1'b0;
      result_q <= {W{1'b0}};
      cout_q   <= 1'b0;
      zero_q   <= 1'b1;
`ifdef ALU_SERIAL_DECIMAL_EN
      inv_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      c_q      <= c_d;
      work_q   <= work_d;
      done_q   <= done_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
`ifdef ALU_SERIAL_DECIMAL_EN
      inv_q    <= inv_d;
`endif
    end
  end

  assign busy   = (state_q == RUN);
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;

endmodule
